// File: rtl/rsa_sched_pkg.sv
// Shared types for the RSA job scheduler: FSM state encoding, requester index,
// default prime width.
package rsa_sched_pkg;

  localparam int WIDTH_DEF = 128;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INV_RST  = 3'd1,
    ST_INV_WAIT = 3'd2,
    ST_EXP_RST  = 3'd3,
    ST_EXP_WAIT = 3'd4,
    ST_RESP     = 3'd5
  } sched_state_t;

  typedef logic req_idx_t;

  function automatic logic [1:0] idx_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rsa_rr_arbiter.sv
// Two-way round-robin grant. On a tie the requester not served last wins; the
// pointer moves on the update strobe and the grant already reflects that move.
module rsa_rr_arbiter
  import rsa_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  req_idx_t   i_upd_idx,
  output logic [1:0] o_grant
);

  req_idx_t r_last;
  req_idx_t w_last_eff;

  // Requester 1 counts as last served so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (i_upd) begin
      r_last <= i_upd_idx;
    end
  end

  assign w_last_eff = i_upd ? i_upd_idx : r_last;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = w_last_eff ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/rsa_job_scheduler.sv
// Two-requester job sequencer for the shared RSA control core.
// Optional key cache (skip inverter phase on repeated p/q): RSA_SCHED_KEY_CACHE_EN.
// Handshakes: a transfer happens on any rising edge where valid and ready are
// both high; valid, once raised, holds with stable data until that edge.
module rsa_job_scheduler
  import rsa_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [WIDTH-1:0]   req_p_0,
  input  logic [WIDTH-1:0]   req_p_1,
  input  logic [WIDTH-1:0]   req_q_0,
  input  logic [WIDTH-1:0]   req_q_1,
  input  logic [1:0]         req_ed,
  input  logic [2*WIDTH-1:0] req_msg_0,
  input  logic [2*WIDTH-1:0] req_msg_1,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [2*WIDTH-1:0] rsp_msg,
  output logic [WIDTH-1:0]   core_p,
  output logic [WIDTH-1:0]   core_q,
  output logic               core_encrypt_decrypt,
  output logic [2*WIDTH-1:0] core_msg_in,
  output logic               core_reset_inverter,
  output logic               core_reset_mod_exp,
  input  logic               core_inverter_finish,
  input  logic               core_mod_exp_finish,
  input  logic [2*WIDTH-1:0] core_msg_out,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  sched_state_t       r_state;
  sched_state_t       w_state_nxt;
  req_idx_t           r_owner;
  logic [1:0]         r_req_ready;
  logic [WIDTH-1:0]   r_core_p;
  logic [WIDTH-1:0]   r_core_q;
  logic               r_core_ed;
  logic [2*WIDTH-1:0] r_core_msg;
  logic [2*WIDTH-1:0] r_rsp_msg;

  logic [1:0]         w_grant;
  logic [1:0]         w_acc_vec;
  logic               w_acc;
  req_idx_t           w_acc_idx;
  logic [WIDTH-1:0]   w_sel_p;
  logic [WIDTH-1:0]   w_sel_q;
  logic               w_sel_ed;
  logic [2*WIDTH-1:0] w_sel_msg;
  logic               w_rsp_hs;
  logic               w_inv_done;
  logic               w_exp_done;
  logic               w_cache_hit;

  assign w_acc_vec = req_valid & r_req_ready;
  assign w_acc     = (r_state == ST_IDLE) && (w_acc_vec != 2'b00);
  assign w_acc_idx = w_acc_vec[1];
  assign w_sel_p   = w_acc_idx ? req_p_1   : req_p_0;
  assign w_sel_q   = w_acc_idx ? req_q_1   : req_q_0;
  assign w_sel_msg = w_acc_idx ? req_msg_1 : req_msg_0;
  assign w_sel_ed  = req_ed[w_acc_idx];

  // Finish levels only count in their own WAIT state; stale highs are ignored.
  assign w_inv_done = (r_state == ST_INV_WAIT) && core_inverter_finish;
  assign w_exp_done = (r_state == ST_EXP_WAIT) && core_mod_exp_finish;
  assign w_rsp_hs   = (r_state == ST_RESP) && rsp_ready[r_owner];

  rsa_rr_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req     (req_valid),
    .i_upd     (w_rsp_hs),
    .i_upd_idx (r_owner),
    .o_grant   (w_grant)
  );

`ifdef RSA_SCHED_KEY_CACHE_EN
  logic [WIDTH-1:0] r_cache_p;
  logic [WIDTH-1:0] r_cache_q;
  logic             r_cache_vld;

  // Operand registers still hold the job's key when the inverter finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cache_p   <= '0;
      r_cache_q   <= '0;
      r_cache_vld <= 1'b0;
    end else if (w_inv_done) begin
      r_cache_p   <= r_core_p;
      r_cache_q   <= r_core_q;
      r_cache_vld <= 1'b1;
    end
  end

  assign w_cache_hit = r_cache_vld && (w_sel_p == r_cache_p) && (w_sel_q == r_cache_q);
`else
  assign w_cache_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_acc) w_state_nxt = w_cache_hit ? ST_EXP_RST : ST_INV_RST;
      ST_INV_RST:  w_state_nxt = ST_INV_WAIT;
      ST_INV_WAIT: if (w_inv_done) w_state_nxt = ST_EXP_RST;
      ST_EXP_RST:  w_state_nxt = ST_EXP_WAIT;
      ST_EXP_WAIT: if (w_exp_done) w_state_nxt = ST_RESP;
      ST_RESP:     if (w_rsp_hs) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= 1'b0;
      r_req_ready <= 2'b00;
      r_core_p    <= '0;
      r_core_q    <= '0;
      r_core_ed   <= 1'b0;
      r_core_msg  <= '0;
      r_rsp_msg   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      // Ready is offered only while the next cycle will be spent in IDLE.
      r_req_ready <= (w_state_nxt == ST_IDLE) ? w_grant : 2'b00;
      if (w_acc) begin
        r_owner    <= w_acc_idx;
        r_core_p   <= w_sel_p;
        r_core_q   <= w_sel_q;
        r_core_ed  <= w_sel_ed;
        r_core_msg <= w_sel_msg;
      end
      if (w_exp_done) begin
        r_rsp_msg <= core_msg_out;
      end
    end
  end

  assign req_ready            = r_req_ready;
  assign rsp_valid            = (r_state == ST_RESP) ? idx_onehot(r_owner) : 2'b00;
  assign rsp_msg              = r_rsp_msg;
  assign core_p               = r_core_p;
  assign core_q               = r_core_q;
  assign core_encrypt_decrypt = r_core_ed;
  assign core_msg_in          = r_core_msg;
  assign core_reset_inverter  = (r_state == ST_INV_RST);
  assign core_reset_mod_exp   = (r_state == ST_EXP_RST);
  assign busy                 = (r_state != ST_IDLE);
  assign dbg_state            = r_state;

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Bench for rsa_job_scheduler: behavioural core model (add/sub keyed by {p,q}),
// scoreboard of expected responses, owners and inverter pulse counts.
module tb_rsa_job_scheduler;
  import rsa_sched_pkg::*;

  localparam int W  = 128;
  localparam int MW = 256;

  logic          clk;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [W-1:0]  req_p_0, req_p_1, req_q_0, req_q_1;
  logic [1:0]    req_ed;
  logic [MW-1:0] req_msg_0, req_msg_1;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [MW-1:0] rsp_msg;
  logic [W-1:0]  core_p, core_q;
  logic          core_encrypt_decrypt;
  logic [MW-1:0] core_msg_in;
  logic          core_reset_inverter, core_reset_mod_exp;
  logic          core_inverter_finish, core_mod_exp_finish;
  logic [MW-1:0] core_msg_out;
  logic          busy;
  logic [2:0]    dbg_state;

  rsa_job_scheduler #(.WIDTH(W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_p_0              (req_p_0),
    .req_p_1              (req_p_1),
    .req_q_0              (req_q_0),
    .req_q_1              (req_q_1),
    .req_ed               (req_ed),
    .req_msg_0            (req_msg_0),
    .req_msg_1            (req_msg_1),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_msg              (rsp_msg),
    .core_p               (core_p),
    .core_q               (core_q),
    .core_encrypt_decrypt (core_encrypt_decrypt),
    .core_msg_in          (core_msg_in),
    .core_reset_inverter  (core_reset_inverter),
    .core_reset_mod_exp   (core_reset_mod_exp),
    .core_inverter_finish (core_inverter_finish),
    .core_mod_exp_finish  (core_mod_exp_finish),
    .core_msg_out         (core_msg_out),
    .busy                 (busy),
    .dbg_state            (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [MW-1:0] exp_q[$];
  logic          own_q[$];
  logic [1:0]    inv_q[$];
  int            n_vec;
  int            n_miss;

  logic [MW-1:0] pend_key[2];
  logic [MW-1:0] pend_msg[2];
  logic          pend_ed[2];
  logic          pend_inv[2];

  logic [W-1:0]  m_cache_p, m_cache_q;
  logic          m_cache_vld;

  task automatic check_val(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] core_fn(input logic [MW-1:0] msg, input logic [W-1:0] p,
                                            input logic [W-1:0] q, input logic ed);
    logic [MW-1:0] key;
    key = {p, q};
    return ed ? (msg - key) : (msg + key);
  endfunction

  // ---------------- core model ----------------
  int unsigned inv_left, exp_left, exp_lo, exp_hi;
  logic        inv_seen, exp_seen;
  int          n_inv, n_exp;

  initial begin
    core_inverter_finish = 1'b0;
    core_mod_exp_finish  = 1'b0;
    core_msg_out         = '0;
    inv_seen = 1'b0; exp_seen = 1'b0;
    inv_left = 0; exp_left = 0;
    exp_lo = 1; exp_hi = 6;
    n_inv = 0; n_exp = 0;
    forever begin
      @(posedge clk); #1;
      // Reacts one cycle late so the finish level is still stale during RST.
      if (inv_seen) begin
        core_inverter_finish = 1'b0;
        inv_left = $urandom_range(1, 5);
      end else if (inv_left > 0) begin
        inv_left--;
        if (inv_left == 0) core_inverter_finish = 1'b1;
      end
      if (exp_seen) begin
        core_mod_exp_finish = 1'b0;
        exp_left = $urandom_range(exp_hi, exp_lo);
      end else if (exp_left > 0) begin
        exp_left--;
        if (exp_left == 0) begin
          core_msg_out = core_fn(core_msg_in, core_p, core_q, core_encrypt_decrypt);
          core_mod_exp_finish = 1'b1;
        end
      end
      inv_seen = core_reset_inverter;
      exp_seen = core_reset_mod_exp;
      if (core_reset_inverter) n_inv++;
      if (core_reset_mod_exp)  n_exp++;
    end
  end

  // ---------------- response monitor ----------------
  int base_inv, base_exp;
  initial begin
    logic [MW-1:0] e_msg;
    logic          e_own;
    logic [1:0]    e_inv;
    base_inv = 0; base_exp = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        base_inv = n_inv;
        base_exp = n_exp;
      end else if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (exp_q.size() == 0) begin
          check_val("rsp_unexpected", {254'd0, rsp_valid}, '0);
        end else begin
          e_msg = exp_q.pop_front();
          e_own = own_q.pop_front();
          e_inv = inv_q.pop_front();
          check_val("rsp_valid", {254'd0, rsp_valid}, {254'd0, idx_onehot(e_own)});
          check_val("rsp_msg", rsp_msg, e_msg);
          check_val("inv_pulses", MW'(n_inv - base_inv), {254'd0, e_inv});
          check_val("exp_pulses", MW'(n_exp - base_exp), 1);
        end
        base_inv = n_inv;
        base_exp = n_exp;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    check_val("rst_outputs", {busy, rsp_valid, req_ready, core_reset_inverter, core_reset_mod_exp,
                              core_encrypt_decrypt, dbg_state}, '0);
    check_val("rst_core_pq", {core_p, core_q}, '0);
    check_val("rst_msgs", core_msg_in | rsp_msg, '0);
    tick();
    reset = 1'b0;
    exp_q.delete(); own_q.delete(); inv_q.delete();
    m_cache_vld = 1'b0;
  endtask

  task automatic drive_req(input int r, input logic [W-1:0] p, input logic [W-1:0] q,
                           input logic ed, input logic [MW-1:0] msg);
    logic hit;
    if (r == 0) begin
      req_p_0 = p; req_q_0 = q; req_msg_0 = msg;
    end else begin
      req_p_1 = p; req_q_1 = q; req_msg_1 = msg;
    end
    req_ed[r]    = ed;
    req_valid[r] = 1'b1;
`ifdef RSA_SCHED_KEY_CACHE_EN
    hit = m_cache_vld && (p == m_cache_p) && (q == m_cache_q);
    m_cache_p = p; m_cache_q = q; m_cache_vld = 1'b1;
`else
    hit = 1'b0;
`endif
    pend_key[r] = {p, q};
    pend_msg[r] = msg;
    pend_ed[r]  = ed;
    pend_inv[r] = !hit;
    exp_q.push_back(core_fn(msg, p, q, ed));
    own_q.push_back(r[0]);
    inv_q.push_back(hit ? 2'd0 : 2'd1);
  endtask

  task automatic wait_accept(input int r);
    int k = 0;
    while (!(req_valid[r] && req_ready[r]) && k < 3000) begin
      tick(); k++;
    end
    if (k >= 3000) begin
      check_val("accept_timeout", {255'd0, req_ready[r]}, 1);
    end else begin
      tick();
      check_val("start_pulse", {254'd0, core_reset_inverter, core_reset_mod_exp},
                pend_inv[r] ? 2'b10 : 2'b01);
      check_val("core_pq", {core_p, core_q}, pend_key[r]);
      check_val("core_msg_in", core_msg_in, pend_msg[r]);
      check_val("core_ed", {255'd0, core_encrypt_decrypt}, {255'd0, pend_ed[r]});
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      tick(); k++;
    end
    if (exp_q.size() != 0) check_val("drain_timeout", exp_q.size(), 0);
    tick();
  endtask

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- main sequence ----------------
  localparam logic [W-1:0] P0 = 128'd113680897410347;
  localparam logic [W-1:0] Q0 = 128'd7999808077935876437321;

  initial begin
    logic [MW-1:0] m1;
    logic [W-1:0]  pa, qa, pb, qb;
    int            k;
    n_vec = 0; n_miss = 0;
    reset = 1'b1;
    req_valid = 2'b00; req_ed = 2'b00;
    req_p_0 = '0; req_p_1 = '0; req_q_0 = '0; req_q_1 = '0;
    req_msg_0 = '0; req_msg_1 = '0;
    rsp_ready = 2'b11;
    m_cache_p = '0; m_cache_q = '0; m_cache_vld = 1'b0;
    tick(); tick();
    do_reset();

    // Single encrypt, then decrypt the result on requester 1.
    drive_req(0, P0, Q0, 1'b0, 256'h57000000);
    wait_accept(0);
    drain();
    m1 = 256'h57000000 + {P0, Q0};
    drive_req(1, P0, Q0, 1'b1, m1);
    check_val("roundtrip_exp", exp_q[0], 256'h57000000);
    wait_accept(1);
    drain();

    // Contention from reset: 0, 1, then 0, 1 again, then after a lone 0 job, 1 first.
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      pa = rnd_w(); qa = rnd_w(); pb = rnd_w(); qb = rnd_w();
      drive_req(0, pa, qa, 1'b0, {rnd_w(), rnd_w()});
      drive_req(1, pb, qb, 1'b1, {rnd_w(), rnd_w()});
      wait_accept(0);
      wait_accept(1);
      drain();
    end
    drive_req(0, rnd_w(), rnd_w(), 1'b0, {rnd_w(), rnd_w()});
    wait_accept(0);
    drain();
    drive_req(1, rnd_w(), rnd_w(), 1'b0, {rnd_w(), rnd_w()});
    drive_req(0, rnd_w(), rnd_w(), 1'b1, {rnd_w(), rnd_w()});
    wait_accept(1);
    wait_accept(0);
    drain();

    // Response backpressure on requester 0 while requester 1 waits.
    rsp_ready = 2'b10;
    drive_req(0, rnd_w(), rnd_w(), 1'b0, {rnd_w(), rnd_w()});
    wait_accept(0);
    drive_req(1, rnd_w(), rnd_w(), 1'b0, {rnd_w(), rnd_w()});
    k = 0;
    while (!rsp_valid[0] && k < 3000) begin tick(); k++; end
    if (!rsp_valid[0]) check_val("rsp_timeout", {254'd0, rsp_valid}, 1);
    for (int c = 0; c < 20; c++) begin
      check_val("bp_msg", rsp_msg, exp_q[0]);
      check_val("bp_busy_ready", {253'd0, busy, req_ready}, {253'd0, 1'b1, 2'b00});
      tick();
    end
    rsp_ready = 2'b11;
    wait_accept(1);
    drain();

    // Reset in EXP_WAIT drops the job; a fresh job then completes.
    exp_lo = 10; exp_hi = 12;
    drive_req(0, P0, Q0, 1'b0, {rnd_w(), rnd_w()});
    wait_accept(0);
    k = 0;
    while (dbg_state != ST_EXP_WAIT && k < 3000) begin tick(); k++; end
    check_val("reach_exp_wait", {253'd0, dbg_state}, {253'd0, ST_EXP_WAIT});
    do_reset();
    exp_lo = 1; exp_hi = 6;
    drive_req(0, P0, Q0, 1'b0, 256'h57000000);
    wait_accept(0);
    drain();

    // Same key again (cache hit when enabled), then a changed q.
    drive_req(1, P0, Q0, 1'b0, 256'h6d9d);
    wait_accept(1);
    drain();
    drive_req(0, P0, Q0 + 128'd2, 1'b0, 256'h6d9d);
    wait_accept(0);
    drain();

    check_val("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
